// File: rtl/custom_types_pkg.sv
// Shared types for the MIPS pipeline front end.
// Holds the fetch latch bundle, jump select encoding and fetch FSM states.
package custom_types_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        JUMP = 2'd1,
        JR   = 2'd2,
        RSVD = 2'd3
    } jumpsel_t;

    typedef struct packed {
        logic [31:0] imemload;
        logic [31:0] NPC;
        logic        valid;
    } fetch_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fstate_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational redirect target and next-PC selection for fetch.
// Pending redirects win over a fresh one; jumps win over branches.
module next_pc_sel
    import custom_types_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_pend_valid,
    input  logic [31:0] i_pend_pc,
    input  logic        i_redirect,
    input  jumpsel_t    i_jumpsel,
    input  logic [31:0] i_jump_addr,
    input  logic [31:0] i_porta,
    input  logic [31:0] i_branch_addr,
    output logic [31:0] o_target,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_npc
);

    always_comb begin
        o_target = i_branch_addr;
        unique case (i_jumpsel)
            JUMP:    o_target = i_jump_addr;
            JR:      o_target = i_porta;
            default: o_target = i_branch_addr;
        endcase
    end

    assign o_pc_plus4 = i_pc + PC_STEP;

    always_comb begin
        o_npc = o_pc_plus4;
        if (i_pend_valid)
            o_npc = i_pend_pc;
        else if (i_redirect)
            o_npc = o_target;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem request, fetch latch and pending redirect.
// Redirects seen while fetch is blocked are parked until the next advance.
module fetch_stage
    import custom_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        freeze,
    input  logic        flush,
    input  logic        halt,
    input  logic [1:0]  JumpSel,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] porta,
    input  logic        BranchTaken,
    input  logic [31:0] BranchAddr,
    output logic [31:0] fetch_imemload,
    output logic [31:0] fetch_NPC,
    output logic        fetch_valid
);

    fstate_t     r_state;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;
    fetch_t      r_fetch;

    jumpsel_t    w_jumpsel;
    logic        w_run;
    logic        w_advance;
    logic        w_redirect;
    logic        w_squash;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_npc;

    assign w_jumpsel  = jumpsel_t'(JumpSel);
    assign w_run      = (r_state == RUN);
    assign w_advance  = ihit & ~freeze & w_run & ~halt;
    assign w_redirect = r_fetch.valid
                      & ((w_jumpsel == JUMP) | (w_jumpsel == JR) | BranchTaken);
    assign w_squash   = r_pend_valid | w_redirect;

    next_pc_sel u_next_pc_sel (
        .i_pc          (r_pc),
        .i_pend_valid  (r_pend_valid),
        .i_pend_pc     (r_pend_pc),
        .i_redirect    (w_redirect),
        .i_jumpsel     (w_jumpsel),
        .i_jump_addr   (JumpAddr),
        .i_porta       (porta),
        .i_branch_addr (BranchAddr),
        .o_target      (w_target),
        .o_pc_plus4    (w_pc_plus4),
        .o_npc         (w_npc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= RUN;
            r_pc         <= PC_INIT;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_fetch      <= '0;
        end else if (halt) begin
            r_state      <= HALTED;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_fetch      <= '0;
        end else begin
            if (w_advance) begin
                r_pc         <= w_npc;
                r_pend_valid <= 1'b0;
            end else if (w_redirect && !r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= w_target;
            end
            // flush beats the latch load but not the PC/pending update
            if (flush)
                r_fetch <= '0;
            else if (w_advance && w_squash)
                r_fetch <= '0;
            else if (w_advance)
                r_fetch <= '{imemload: imemload, NPC: w_pc_plus4, valid: 1'b1};
        end
    end

    assign imemREN        = w_run;
    assign imemaddr       = r_pc;
    assign fetch_imemload = r_fetch.imemload;
    assign fetch_NPC      = r_fetch.NPC;
    assign fetch_valid    = r_fetch.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front pipeline stage of the five-stage MIPS core. Holds the PC, issues instruction-memory reads, and fills the fetch pipeline latch (instruction word, next PC, valid) that the decode stage consumes. Also applies the branch/jump redirects that decode resolves against that same latch. Redirects that arrive while a fetch is blocked are kept in a one-entry pending register until the stage advances.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  instruction memory returned imemload for imemaddr this cycle.
- imemload  in  32  instruction word.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address (= PC).
- freeze  in  1  hazard-unit stall; stage must not advance.
- flush  in  1  clear fetch latch.
- halt  in  1  halt retired; stop fetching.
- JumpSel  in  2  0 none, 1 j/jal, 2 jr, 3 reserved (treated as 0).
- JumpAddr  in  32  j/jal target.
- porta  in  32  jr target (rs value).
- BranchTaken  in  1  taken-branch indication.
- BranchAddr  in  32  branch target.
- fetch_imemload  out  32  latched instruction.
- fetch_NPC  out  32  latched PC+4 of that instruction.
- fetch_valid  out  1  latch holds a real instruction.

## Operation
- States: RUN, HALTED. Reset → RUN. RUN → HALTED when halt=1. HALTED exits only by RST.
- imemREN = (state==RUN). imemaddr = PC (combinational from register).
- advance = ihit & ~freeze & (state==RUN) & ~halt.
- redirect_now = fetch_valid & (JumpSel==1 | JumpSel==2 | BranchTaken).
- target: JumpSel==1 → JumpAddr; JumpSel==2 → porta; else BranchAddr. A jump overrides BranchTaken.
- next PC on advance: pend_valid → pend_pc; else redirect_now → target; else PC+4. PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 = 0.
- Latch on advance: if pend_valid or redirect_now, load zeros (wrong-path squash, valid=0). Otherwise load {imemload, PC+4, 1}.
- Pending capture: redirect_now & ~advance & ~pend_valid → pend_valid=1, pend_pc=target. An existing pending entry is never overwritten. pend_valid clears on advance.
- Priority per cycle: RST > halt > flush > advance > hold.
  - halt: latch cleared, PC held, pending cleared.
  - flush: latch cleared. PC and pending still update per advance/capture rules.
  - No advance: PC and latch hold.

## Timing
- Reset values:
  - PC = PC_INIT.
  - fetch_imemload, fetch_NPC, fetch_valid = 0.
  - pend_valid = 0, pend_pc = 0.
  - state = RUN.
  - imemREN = 1 from the first cycle after RST deasserts.
- RST asserted mid-stall or with a redirect pending discards everything.
- Latency:
  - Instruction at PC appears in the latch on the edge where ihit=1.
  - A redirect is visible on imemaddr one cycle after the advancing edge.
  - Throughput is one instruction per cycle with ihit held high.
- halt=1 → imemREN=0 on the following cycle. ihit is ignored while HALTED.

## Structure
- custom_types_pkg gains fetch_t {imemload, NPC, valid} and the jumpsel_t enum (NONE, JUMP, JR, RSVD).
- One sub-module, next_pc_sel: a combinational target/next-PC mux. The PC, pending register, latch and FSM stay in fetch_stage.

## Test plan
- Sequential fetch: RST 2 cycles, then ihit=1 constantly, imemload=0x2001_0005 → imemaddr 0,4,8. After the first edge the latch holds {0x2001_0005, 4, 1}.
- Miss stall and freeze:
  - ihit=0 for 3 cycles at PC=8 → imemaddr stays 8 and the latch is unchanged.
  - freeze=1 with ihit=1 → same result.
- Taken branch: latch valid, BranchTaken=1, BranchAddr=0x40, ihit=1 → PC=0x40 next cycle, fetch_valid=0.
- Redirect during miss:
  - JumpSel=1, JumpAddr=0x100 with ihit=0 for 2 cycles, then JumpSel=0 with ihit=1 → PC=0x100, latch squashed.
  - A second redirect during the pending window is ignored.
- jr priority: JumpSel=2, porta=0x80, BranchTaken=1, BranchAddr=0x40, ihit=1 → PC=0x80.
- Halt:
  - halt=1 → imemREN=0 next cycle, PC frozen, latch zero, later ihit pulses ignored.
  - RST → PC=PC_INIT, imemREN=1.
